// File: rtl/montgomery_mmm_stream.sv
// Radix-2 Montgomery multiplier: P = A*B*2^-K mod m, K_BITS+2 cycles accept-to-valid (1 for rejected ops).
// Single request in flight, no input buffering; the result holds in DONE until i_Ready.
module montgomery_mmm_stream #(
  parameter int K_BITS    = 8,
  parameter bit CHECK_OPS = 1'b1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [K_BITS-1:0] i_A,
  input  logic [K_BITS-1:0] i_B,
  input  logic [K_BITS-1:0] i_m,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [K_BITS-1:0] o_P,
  output logic              o_Err
);

  typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_t;

  localparam int CW = $clog2(K_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(K_BITS - 1);

  state_t            state, state_nxt;
  logic [K_BITS-1:0] a_q, b_q, m_q;
  logic [K_BITS:0]   p_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q;

  logic              illegal;
  logic [K_BITS+1:0] z, z_red;
  logic [K_BITS:0]   p_iter, p_final;
  logic              unused_lsb;

  always_comb begin
    illegal = CHECK_OPS && (!i_m[0] || (i_m < K_BITS'(3)) || (i_A >= i_m) || (i_B >= i_m));
  end

  // a_q is shifted right each iteration so bit 0 is always the current multiplier bit
  always_comb begin
    z                   = {1'b0, p_q} + (a_q[0] ? {2'b00, b_q} : '0);
    z_red               = z + (z[0] ? {2'b00, m_q} : '0);
    {p_iter, unused_lsb} = z_red;
    p_final             = (p_q >= {1'b0, m_q}) ? (p_q - {1'b0, m_q}) : p_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Valid) state_nxt = illegal ? DONE : ITER;
      ITER:    if (cnt_q == LAST) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (i_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Valid) begin
            a_q   <= i_A;
            b_q   <= i_B;
            m_q   <= i_m;
            p_q   <= '0;
            cnt_q <= '0;
            err_q <= illegal;
          end
        end
        ITER: begin
          p_q   <= p_iter;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CW'(1);
        end
        FINAL:   p_q <= p_final;
        default: ;
      endcase
    end
  end

  assign o_Ready = (state == IDLE);
  assign o_Valid = (state == DONE);
  assign o_P     = (state == DONE) ? p_q[K_BITS-1:0] : '0;
  assign o_Err   = (state == DONE) && err_q;

endmodule

// File: tb/tb_montgomery_mmm_stream.sv
// Directed and randomized checks of montgomery_mmm_stream (K_BITS=8) against an arithmetic reference.
module tb_montgomery_mmm_stream;

  logic       tb_Clk = 1'b0;
  logic       i_Rst_n, i_Valid, i_Ready;
  logic [7:0] i_A, i_B, i_m;
  logic       o_Ready, o_Valid, o_Err;
  logic [7:0] o_P;

  int n_assert = 0;
  int n_fail   = 0;

  montgomery_mmm_stream #(.K_BITS(8), .CHECK_OPS(1'b1)) dut (
    .i_Clk  (tb_Clk),
    .i_Rst_n(i_Rst_n),
    .i_Valid(i_Valid),
    .o_Ready(o_Ready),
    .i_A    (i_A),
    .i_B    (i_B),
    .i_m    (i_m),
    .o_Valid(o_Valid),
    .i_Ready(i_Ready),
    .o_P    (o_P),
    .o_Err  (o_Err)
  );

  always #5 tb_Clk = ~tb_Clk;

  // A*B*2^-8 mod m computed directly from modular arithmetic
  function automatic int mont_ref(input int a, input int b, input int m);
    longint rinv = 0;
    for (int x = 1; x < m; x++)
      if (rinv == 0 && ((256 * x) % m) == 1) rinv = x;
    return int'((((longint'(a) * b) % m) * rinv) % m);
  endfunction

  function automatic bit is_illegal(input int a, input int b, input int m);
    return (m % 2 == 0) || (m < 3) || (a >= m) || (b >= m);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a request, wait for acceptance, then scramble the inputs; returns at the negedge after accept
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int w = 0;
    i_A = a; i_B = b; i_m = m; i_Valid = 1'b1;
    while (!o_Ready && w < 40) begin
      @(negedge tb_Clk);
      w++;
    end
    check("accept_ready", 32'(o_Ready), 32'd1);
    @(negedge tb_Clk);
    i_Valid = 1'b0;
    i_A = 8'($urandom); i_B = 8'($urandom); i_m = 8'($urandom);
  endtask

  task automatic wait_valid(input int exp_p, input bit exp_err, input int exp_lat, input bit poke);
    int n = 0;
    while (!o_Valid && n < 40) begin
      check("p_zero_not_valid", 32'(o_P), 32'd0);
      if (poke && n == 3) begin
        check("busy_not_ready", 32'(o_Ready), 32'd0);
        i_Valid = 1'b1; i_A = 8'd5; i_B = 8'd7; i_m = 8'd101;
      end
      if (poke && n == 5) i_Valid = 1'b0;
      @(negedge tb_Clk);
      n++;
    end
    check("latency", 32'(n + 1), 32'(exp_lat));
    check("valid", 32'(o_Valid), 32'd1);
    check("result_p", 32'(o_P), 32'(exp_p));
    check("result_err", 32'(o_Err), 32'(exp_err));
  endtask

  task automatic release_result(input int hold, input int exp_p, input bit exp_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge tb_Clk);
      check("hold_valid", 32'(o_Valid), 32'd1);
      check("hold_p", 32'(o_P), 32'(exp_p));
      check("hold_err", 32'(o_Err), 32'(exp_err));
    end
    i_Ready = 1'b1;
    @(negedge tb_Clk);
    check("handoff_valid", 32'(o_Valid), 32'd0);
    check("handoff_ready", 32'(o_Ready), 32'd1);
    check("handoff_p", 32'(o_P), 32'd0);
  endtask

  initial begin
    bit saw_valid;
    int a, b, m, hold, exp_p;
    bit ill;

    i_Rst_n = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
    i_A = '0; i_B = '0; i_m = '0;
    repeat (3) @(negedge tb_Clk);
    check("rst_ready", 32'(o_Ready), 32'd1);
    check("rst_valid", 32'(o_Valid), 32'd0);
    check("rst_err", 32'(o_Err), 32'd0);
    check("rst_p", 32'(o_P), 32'd0);
    i_Rst_n = 1'b1;
    @(negedge tb_Clk);

    // Basic result and latency
    issue(8'd211, 8'd198, 8'd225);
    wait_valid(63, 1'b0, 10, 1'b0);
    release_result(0, 63, 1'b0);

    // Back-to-back: the next request is held at the handoff edge and accepted one cycle later
    issue(8'd1, 8'd2, 8'd225);
    wait_valid(167, 1'b0, 10, 1'b0);
    i_A = 8'd10; i_B = 8'd20; i_m = 8'd101; i_Valid = 1'b1;
    @(negedge tb_Clk);
    check("b2b_no_valid", 32'(o_Valid), 32'd0);
    check("b2b_ready_after_handoff", 32'(o_Ready), 32'd1);
    @(negedge tb_Clk);
    i_Valid = 1'b0;
    check("b2b_accepted", 32'(o_Ready), 32'd0);
    wait_valid(86, 1'b0, 10, 1'b0);
    release_result(0, 86, 1'b0);

    // Backpressure for five cycles
    i_Ready = 1'b0;
    issue(8'd0, 8'd198, 8'd225);
    wait_valid(0, 1'b0, 10, 1'b0);
    release_result(5, 0, 1'b0);

    // Illegal operands
    issue(8'd3, 8'd5, 8'd224);
    wait_valid(0, 1'b1, 1, 1'b0);
    release_result(0, 0, 1'b1);
    issue(8'd230, 8'd5, 8'd225);
    wait_valid(0, 1'b1, 1, 1'b0);
    release_result(0, 0, 1'b1);

    // Reset at iteration 4 discards the operation
    issue(8'd211, 8'd198, 8'd225);
    repeat (4) @(negedge tb_Clk);
    i_Rst_n = 1'b0;
    @(negedge tb_Clk);
    i_Rst_n = 1'b1;
    check("midrst_ready", 32'(o_Ready), 32'd1);
    check("midrst_valid", 32'(o_Valid), 32'd0);
    check("midrst_p", 32'(o_P), 32'd0);
    saw_valid = 1'b0;
    repeat (15) begin
      @(negedge tb_Clk);
      if (o_Valid) saw_valid = 1'b1;
    end
    check("midrst_no_valid", 32'(saw_valid), 32'd0);
    issue(8'd211, 8'd198, 8'd225);
    wait_valid(63, 1'b0, 10, 1'b0);
    release_result(0, 63, 1'b0);

    // i_Valid pulsed with new operands while busy is ignored
    issue(8'd211, 8'd198, 8'd225);
    wait_valid(63, 1'b0, 10, 1'b1);
    release_result(0, 63, 1'b0);
    check("poke_not_queued", 32'(o_Ready), 32'd1);

    // Randomized legal and illegal requests
    for (int t = 0; t < 30; t++) begin
      m = $urandom_range(1, 127) * 2 + 1;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      case ($urandom_range(0, 5))
        0: m = $urandom_range(0, 127) * 2;
        1: a = $urandom_range(m, 255);
        default: ;
      endcase
      ill   = is_illegal(a, b, m);
      exp_p = ill ? 0 : mont_ref(a, b, m);
      hold  = $urandom_range(0, 2);
      i_Ready = (hold == 0);
      issue(8'(a), 8'(b), 8'(m));
      wait_valid(exp_p, ill, ill ? 1 : 10, 1'b0);
      release_result(hold, exp_p, ill);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
